// File: rtl/chunked_adder.sv
// chunked_adder
// Multi-cycle adder/subtractor. Operands of WIDTH bits are summed CHUNK bits
// per cycle, LSB slice first, over N = WIDTH/CHUNK cycles, so the carry chain
// per cycle is only CHUNK bits long. Subtraction is a + ~b + 1.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active-high
//   valid_i  operands valid          ready_o  operands accepted (IDLE only)
//   a_i,b_i  operands                sub_i    0: a+b, 1: a-b
//   valid_o  result valid            ready_i  downstream accepts result
//   o        result mod 2^WIDTH
//   carry_o  carry out of MSB (subtract: 1 = no borrow)
//   ovf_o    two's-complement overflow
//
// state | meaning
// IDLE  | waiting for operands, ready_o = 1
// CALC  | summing one slice per cycle
// DONE  | result presented, waiting for ready_i
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   sl_sum;
  logic             accept, last, ovf_nxt;

  assign accept = (state == IDLE) && valid_i;
  assign last   = (state == CALC) && (cnt_q == LAST);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[k*CHUNK +: CHUNK];
        b_sl = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    acc_nxt = acc_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) acc_nxt[k*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
    end
  end

  // On the last slice sl_sum[CHUNK-1] is result bit WIDTH-1; overflow when the
  // operand signs agree but the result sign differs (same as cin^cout at MSB).
  assign ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[CHUNK-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nxt = CALC;
      end
      CALC: begin
        if (cnt_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      o       <= '0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i;
      cnt_q   <= '0;
    end else if (state == CALC) begin
      acc_q   <= acc_nxt;
      carry_q <= sl_sum[CHUNK];
      if (last) begin
        o       <= acc_nxt;
        carry_o <= sl_sum[CHUNK];
        ovf_o   <= ovf_nxt;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, 4-bit slices
  logic        vin16 = 1'b0, sub16 = 1'b0, rin16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, vout16, c16, v16;
  logic [15:0] o16;

  // 8-bit, single slice
  logic        vin8 = 1'b0, sub8 = 1'b0, rin8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, vout8, c8, v8;
  logic [7:0]  o8;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(vin16), .ready_o(rdy16),
    .a_i(a16), .b_i(b16), .sub_i(sub16), .valid_o(vout16), .ready_i(rin16),
    .o(o16), .carry_o(c16), .ovf_o(v16));

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(vin8), .ready_o(rdy8),
    .a_i(a8), .b_i(b8), .sub_i(sub8), .valid_o(vout8), .ready_i(rin8),
    .o(o8), .carry_o(c8), .ovf_o(v8));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sub;
    logic [15:0] o;
    bit          c;
    bit          v;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference from signed/unsigned integer arithmetic, not slice by slice.
  task automatic model(input int w, input longint a, input longint b, input bit sub,
                       output longint ro, output bit rc, output bit rv);
    longint m, sa, sb, r;
    m = longint'(1) << w;
    if (sub) begin
      rc = (a >= b);
      ro = ((a - b) % m + m) % m;
    end else begin
      rc = ((a + b) >= m);
      ro = (a + b) % m;
    end
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = sub ? sa - sb : sa + sb;
    rv = (r < -(m / 2)) || (r >= m / 2);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sub,
                      input bit disturb, output logic [15:0] ro, output bit rc,
                      output bit rv, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy16 && w < 20) begin @(negedge clk); w++; end
    chk("ready16_before_op", rdy16, 1);
    a16 = a; b16 = b; sub16 = sub; vin16 = 1'b1;
    @(negedge clk);
    vin16 = 1'b0;
    lat = 0;
    while (!vout16 && lat < 20) begin
      if (disturb) begin
        vin16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    vin16 = 1'b0;
    ro = o16; rc = c16; rv = v16;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sub,
                     output logic [7:0] ro, output bit rc, output bit rv, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy8 && w < 20) begin @(negedge clk); w++; end
    chk("ready8_before_op", rdy8, 1);
    a8 = a; b8 = b; sub8 = sub; vin8 = 1'b1;
    @(negedge clk);
    vin8 = 1'b0;
    lat = 0;
    while (!vout8 && lat < 20) begin @(negedge clk); lat++; end
    ro = o8; rc = c8; rv = v8;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] r16;
    logic [7:0]  r8;
    bit          rc, rv, ec, ev;
    longint      eo;
    int          lat, seen;

    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'hA5C3, 16'h0000, 1'b1, 16'hA5C3, 1'b1, 1'b0};

    // reset for two edges
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_o", o16, 0);
    chk("rst_carry", c16, 0);
    chk("rst_ovf", v16, 0);
    chk("rst_valid", vout16, 0);
    chk("rst_ready", rdy16, 1);
    chk("rst8_ready", rdy8, 1);
    chk("rst8_valid", vout8, 0);

    // directed vectors
    for (int i = 0; i < 7; i++) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, r16, rc, rv, lat);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_o", i), r16, vecs[i].o);
      chk($sformatf("vec%0d_carry", i), rc, vecs[i].c);
      chk($sformatf("vec%0d_ovf", i), rv, vecs[i].v);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_back", i), rdy16, 1);
      chk($sformatf("vec%0d_valid_drop", i), vout16, 0);
    end

    // back-pressure in DONE
    rin16 = 1'b0;
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, r16, rc, rv, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", vout16, 1);
      chk("hold_o", o16, 16'h8000);
      chk("hold_carry", c16, 0);
      chk("hold_ovf", v16, 1);
      chk("hold_ready", rdy16, 0);
    end
    rin16 = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", vout16, 0);
    chk("hold_release_ready", rdy16, 1);

    // input noise during CALC must not disturb the captured operands
    op16(16'h1234, 16'h1111, 1'b0, 1'b1, r16, rc, rv, lat);
    chk("noise_lat", lat, 4);
    chk("noise_o", r16, 16'h2345);
    chk("noise_carry", rc, 0);
    chk("noise_ovf", rv, 0);

    // reset during CALC abandons the operation
    @(negedge clk);
    a16 = 16'h0005; b16 = 16'h0006; sub16 = 1'b0; vin16 = 1'b1;
    @(negedge clk);
    vin16 = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_ready", rdy16, 1);
    chk("midrst_o", o16, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (vout16) seen++;
    end
    chk("midrst_no_valid", seen, 0);

    // single-slice configuration
    op8(8'hFF, 8'h01, 1'b0, r8, rc, rv, lat);
    chk("n1_lat", lat, 1);
    chk("n1_o", r8, 8'h00);
    chk("n1_carry", rc, 1);
    chk("n1_ovf", rv, 0);

    // random against the arithmetic model
    for (int i = 0; i < 100; i++) begin
      logic [15:0] ra, rb;
      bit rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      model(16, longint'(ra), longint'(rb), rs, eo, ec, ev);
      op16(ra, rb, rs, 1'b0, r16, rc, rv, lat);
      chk("rnd16_o", r16, eo);
      chk("rnd16_carry", rc, ec);
      chk("rnd16_ovf", rv, ev);
    end
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      bit rs;
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      model(8, longint'(ra), longint'(rb), rs, eo, ec, ev);
      op8(ra, rb, rs, r8, rc, rv, lat);
      chk("rnd8_o", r8, eo);
      chk("rnd8_carry", rc, ec);
      chk("rnd8_ovf", rv, ev);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
